pc_unit_ras: RTL and testbench

Parametrised program-counter unit for the CPU fetch stage. It keeps the increment, PC-relative branch, skip and absolute jump redirects. It adds a stall hold, call/return redirects backed by a return-address stack (RAS) with configurable depth, and status outputs. Its output drives the instruction-memory address.

---
 rtl/pc_unit_ras.sv | 118 +++++++++++
 tb/tb_pc_unit_ras.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with branch/skip/jump redirects and a
// circular return-address stack driving call/return redirects.
module pc_unit_ras #(
  parameter int unsigned         WIDTH      = 32,
  parameter int unsigned         RAS_DEPTH  = 4,
  parameter int unsigned         STEP       = 1,
  parameter logic [WIDTH-1:0]    RESET_ADDR = '0,
  localparam int unsigned        CW         = $clog2(RAS_DEPTH + 1),
  localparam int unsigned        PW         = $clog2(RAS_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             skip,
  input  logic             jmp,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [CW-1:0]    ras_count,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  // r_ptr is the next free slot; when full it also indexes the oldest entry.
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_pc_d;
  logic [PW-1:0]    w_ptr_d;
  logic [CW-1:0]    w_count_d;
  logic             w_push;
  logic             w_ovf_d;
  logic             w_unf_d;
  logic [PW-1:0]    w_top_idx;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_pc_inc;
  logic             w_empty;
  logic             w_full;

  assign w_top_idx = r_ptr - PW'(1);
  assign w_top     = r_ras[w_top_idx];
  assign w_pc_inc  = r_pc + WIDTH'(STEP);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(RAS_DEPTH));

  always_comb begin
    w_pc_d    = w_pc_inc;
    w_ptr_d   = r_ptr;
    w_count_d = r_count;
    w_push    = 1'b0;
    w_ovf_d   = 1'b0;
    w_unf_d   = 1'b0;
    if (stall) begin
      w_pc_d = r_pc;
    end else if (ret) begin
      if (!w_empty) begin
        w_pc_d    = w_top;
        w_ptr_d   = w_top_idx;
        w_count_d = r_count - CW'(1);
      end else begin
        w_unf_d = 1'b1;
      end
    end else if (call) begin
      w_push  = 1'b1;
      w_pc_d  = target;
      w_ptr_d = r_ptr + PW'(1);
      if (w_full) begin
        w_ovf_d = 1'b1;
      end else begin
        w_count_d = r_count + CW'(1);
      end
    end else if (jmp) begin
      w_pc_d = target;
    end else if (branch) begin
      w_pc_d = r_pc + branch_offset;
    end else if (skip) begin
      w_pc_d = r_pc + WIDTH'(2 * STEP);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= RESET_ADDR;
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc    <= w_pc_d;
      r_ptr   <= w_ptr_d;
      r_count <= w_count_d;
      r_ovf   <= w_ovf_d;
      r_unf   <= w_unf_d;
    end
  end

  // Entry contents need no reset; validity is tracked by r_count.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_ras[r_ptr] <= w_pc_inc;
    end
  end

  assign pc            = r_pc;
  assign ras_count     = r_count;
  assign ras_top       = w_empty ? RESET_ADDR : w_top;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed vector table for the documented scenarios,
// then random stimulus against a queue-based reference model.
module tb_pc_unit_ras;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, branch, skip, jmp, call, ret;
  logic [31:0] branch_offset, target;
  logic [31:0] pc, ras_top;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  int checks = 0;
  int errors = 0;

  pc_unit_ras #(
    .WIDTH(32), .RAS_DEPTH(4), .STEP(1), .RESET_ADDR(32'h0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch       (branch),
    .branch_offset(branch_offset),
    .skip         (skip),
    .jmp          (jmp),
    .call         (call),
    .ret          (ret),
    .target       (target),
    .pc           (pc),
    .ras_count    (ras_count),
    .ras_top      (ras_top),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, stl, br, sk, jp, cl, rt;
    logic [31:0] off, tgt;
    logic [31:0] e_pc;
    int          e_cnt;
    logic [31:0] e_top;
    logic        e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst, stl, br, sk, jp, cl, rt,
                   input logic [31:0] off, tgt, e_pc, input int e_cnt,
                   input logic [31:0] e_top, input logic e_ovf, e_unf);
    vec_t x;
    x.rst = rst; x.stl = stl; x.br = br; x.sk = sk; x.jp = jp; x.cl = cl; x.rt = rt;
    x.off = off; x.tgt = tgt; x.e_pc = e_pc; x.e_cnt = e_cnt; x.e_top = e_top;
    x.e_ovf = e_ovf; x.e_unf = e_unf;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, stl, br, sk, jp, cl, rt, input logic [31:0] off, tgt);
    reset = rst; stall = stl; branch = br; skip = sk; jmp = jp; call = cl; ret = rt;
    branch_offset = off; target = tgt;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input logic [31:0] e_pc, input int e_cnt, input logic [31:0] e_top,
                           input logic e_ovf, input logic e_unf);
    chk("pc", pc, e_pc);
    chk("ras_count", 32'(ras_count), 32'(e_cnt));
    chk("ras_top", ras_top, e_top);
    chk("ras_overflow", 32'(ras_overflow), 32'(e_ovf));
    chk("ras_underflow", 32'(ras_underflow), 32'(e_unf));
  endtask

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_unf;

  task automatic model_step(input logic rst, stl, br, sk, jp, cl, rt, input logic [31:0] off, tgt);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (rst) begin
      m_pc = 32'h0;
      m_ras.delete();
    end else if (stl) begin
      // hold
    end else if (rt) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc  = m_pc + 32'd1;
        m_unf = 1'b1;
      end
    end else if (cl) begin
      m_ras.push_back(m_pc + 32'd1);
      if (m_ras.size() > 4) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_pc = tgt;
    end else if (jp) m_pc = tgt;
    else if (br) m_pc = m_pc + off;
    else if (sk) m_pc = m_pc + 32'd2;
    else m_pc = m_pc + 32'd1;
  endtask

  initial begin
    reset = 1'b1; stall = 0; branch = 0; skip = 0; jmp = 0; call = 0; ret = 0;
    branch_offset = 0; target = 0;

    //  rst stl br sk jp cl rt  off           tgt           pc            cnt top        ovf unf
    v(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h1,        0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2,        0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h3,        0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h4,        0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 1, 0, 0, 32'h0,        32'd10,       32'd10,       0, 32'h0,  0, 0);
    v(0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h0,        32'd6,        0, 32'h0,  0, 0);
    v(0, 0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'd8,        0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 1, 0, 0, 32'h0,        32'h100,      32'h100,      0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 1, 0, 0, 32'h0,        32'h20,       32'h20,       0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h80,       32'h80,       1, 32'h21, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h81,       1, 32'h21, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h82,       1, 32'h21, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h21,       0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h10,       32'h10,       1, 32'h1,  0, 0);
    v(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h20,       32'h20,       2, 32'h11, 0, 0);
    v(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h30,       32'h30,       3, 32'h21, 0, 0);
    v(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h40,       32'h40,       4, 32'h31, 0, 0);
    v(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h50,       32'h50,       4, 32'h41, 1, 0);
    v(0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h41,       3, 32'h31, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h31,       2, 32'h21, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h21,       1, 32'h11, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h11,       0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h12,       0, 32'h0,  0, 1);
    v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h13,       0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h200,      32'h200,      1, 32'h14, 0, 0);
    v(0, 1, 1, 0, 0, 1, 1, 32'h8,        32'h300,      32'h200,      1, 32'h14, 0, 0);
    v(0, 1, 1, 0, 0, 1, 1, 32'h8,        32'h300,      32'h200,      1, 32'h14, 0, 0);
    v(0, 1, 1, 0, 0, 1, 1, 32'h8,        32'h300,      32'h200,      1, 32'h14, 0, 0);
    v(0, 0, 0, 0, 0, 1, 1, 32'h0,        32'h300,      32'h14,       0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 1, 0, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 1, 0, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h40,       32'h40,       1, 32'h0,  0, 0);
    v(1, 0, 0, 0, 0, 1, 0, 32'h0,        32'h90,       32'h0,        0, 32'h0,  0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h1,        0, 32'h0,  0, 1);
    v(1, 1, 1, 0, 0, 0, 0, 32'h8,        32'h0,        32'h0,        0, 32'h0,  0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].sk, vecs[i].jp, vecs[i].cl,
            vecs[i].rt, vecs[i].off, vecs[i].tgt);
      check_all(vecs[i].e_pc, vecs[i].e_cnt, vecs[i].e_top, vecs[i].e_ovf, vecs[i].e_unf);
    end

    // Random phase against the reference model.
    m_pc = 32'h0;
    m_ras.delete();
    for (int i = 0; i < 2000; i++) begin
      logic rs, st, br, sk, jp, cl, rt;
      logic [31:0] off, tgt;
      rs  = (i == 0) || ($urandom_range(0, 99) < 2);
      st  = $urandom_range(0, 99) < 10;
      br  = $urandom_range(0, 99) < 20;
      sk  = $urandom_range(0, 99) < 20;
      jp  = $urandom_range(0, 99) < 10;
      cl  = $urandom_range(0, 99) < 25;
      rt  = $urandom_range(0, 99) < 25;
      off = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8;
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      model_step(rs, st, br, sk, jp, cl, rt, off, tgt);
      drive(rs, st, br, sk, jp, cl, rt, off, tgt);
      check_all(m_pc, m_ras.size(), (m_ras.size() > 0) ? m_ras[$] : 32'h0, m_ovf, m_unf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
